// File: rtl/mmult_hw_sdiv_16s_8s_16_seq.sv
// ---------------------------------------------------------------------------
// mmult_hw_sdiv_16s_8s_16_seq
//
// Iterative signed divider: 16-bit signed dividend / 8-bit signed divisor ->
// 16-bit quotient + 8-bit remainder. Companion to the 16s x 8s multiplier
// core. It rescales accumulated products back into the operand domain.
// Latency is fixed (done is high 18 ce-enabled cycles after the cycle with an
// accepted start), and every register is ce-gated so a scheduler can treat
// it like the multiplier pipelines.
//
// Semantics: C-style truncation toward zero. The remainder carries the sign
// of the dividend. Divide-by-zero saturates the quotient, returns dividend[7:0]
// as the remainder and raises div_by_zero.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   ce           clock enable; when low, all state and outputs freeze
//   start        request; taken when ce=1 and ready=1
//   dividend     signed dividend, captured on accept
//   divisor      signed divisor, captured on accept
//   ready        high in IDLE and DONE (a new start may be accepted)
//   done         result-valid pulse (stretched while ce is low)
//   quotient     signed quotient, held until the next done
//   remainder    signed remainder, held until the next done
//   div_by_zero  divisor was zero for the held result
// ---------------------------------------------------------------------------
module mmult_hw_sdiv_16s_8s_16_seq #(
    parameter logic [31:0] ID         = 32'd1,
    parameter int          DIVIDEND_W = 16,
    parameter int          DIVISOR_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  ready,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    // The instance identifier has no functional effect.
    localparam logic [31:0] UNUSED_ID = ID;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;        // CALC iteration 0..15
    logic [16:0] rem_q;        // unsigned partial remainder
    logic [15:0] quo_q;        // dividend magnitude shifting out, quotient shifting in
    logic [8:0]  dvs_q;        // divisor magnitude; 9 bits so that |-128| fits
    logic        qneg_q;       // quotient is negative
    logic        rneg_q;       // remainder is negative (dividend sign)
    logic        dbz_q;        // divisor was zero
    logic [7:0]  dvd_lo_q;     // raw dividend[7:0], the divide-by-zero remainder

    logic        ready_q;
    logic        done_q;
    logic [15:0] quotient_q;
    logic [7:0]  remainder_q;
    logic        dbz_out_q;

    // Operand magnitudes. -32768 maps to 16'h8000, which is correct as unsigned.
    logic [15:0] dvd_mag_d;
    logic [8:0]  dvs_mag_d;

    // One restoring radix-2 step.
    logic [16:0] rem_sh_d;
    logic [16:0] rem_sub_d;
    logic        ge_d;
    logic [16:0] step_rem_d;
    logic [15:0] step_quo_d;

    // Sign fix-up and divide-by-zero override.
    logic [15:0] q_fix_d;
    logic [7:0]  r_fix_d;

    // The remainder never exceeds 127, so the top bit only carries the spare
    // headroom of the 17-bit subtractor.
    logic        unused_rem_msb;
    assign unused_rem_msb = rem_q[16];

    always_comb begin
        dvd_mag_d  = dividend[15] ? (~dividend + 16'd1) : dividend;
        dvs_mag_d  = divisor[7] ? (~{1'b1, divisor} + 9'd1) : {1'b0, divisor};

        rem_sh_d   = {rem_q[15:0], quo_q[15]};
        rem_sub_d  = rem_sh_d - {8'd0, dvs_q};
        ge_d       = (rem_sh_d >= {8'd0, dvs_q});
        step_rem_d = ge_d ? rem_sub_d : rem_sh_d;
        step_quo_d = {quo_q[14:0], ge_d};

        if (dbz_q) begin
            q_fix_d = rneg_q ? 16'h8000 : 16'h7FFF;
            r_fix_d = dvd_lo_q;
        end else begin
            q_fix_d = qneg_q ? (~quo_q + 16'd1) : quo_q;
            r_fix_d = rneg_q ? (~rem_q[7:0] + 8'd1) : rem_q[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            dbz_q       <= 1'b0;
            dvd_lo_q    <= '0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_out_q   <= 1'b0;
        end else if (ce) begin
            case (state_q)
                // ready is always high here, so start alone means accept.
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q  <= CALC;
                        cnt_q    <= '0;
                        rem_q    <= '0;
                        quo_q    <= dvd_mag_d;
                        dvs_q    <= dvs_mag_d;
                        qneg_q   <= dividend[15] ^ divisor[7];
                        rneg_q   <= dividend[15];
                        dbz_q    <= (divisor == 8'd0);
                        dvd_lo_q <= dividend[7:0];
                        ready_q  <= 1'b0;
                    end else begin
                        state_q  <= IDLE;
                        ready_q  <= 1'b1;
                    end
                end
                // Steps still run on a zero divisor; FIX overrides the result.
                CALC: begin
                    rem_q <= step_rem_d;
                    quo_q <= step_quo_d;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd15) state_q <= FIX;
                end
                FIX: begin
                    quotient_q  <= q_fix_d;
                    remainder_q <= r_fix_d;
                    dbz_out_q   <= dbz_q;
                    done_q      <= 1'b1;
                    ready_q     <= 1'b1;
                    state_q     <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready       = ready_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_out_q;

endmodule

// File: tb/tb_mmult_hw_sdiv_16s_8s_16_seq.sv
module tb_mmult_hw_sdiv_16s_8s_16_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        ready;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    int checks = 0;
    int failures = 0;

    mmult_hw_sdiv_16s_8s_16_seq #(.ID(32'd1), .DIVIDEND_W(16), .DIVISOR_W(8)) dut (
        .clk(clk), .reset(reset), .ce(ce), .start(start),
        .dividend(dividend), .divisor(divisor),
        .ready(ready), .done(done), .quotient(quotient),
        .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] dvd;
        logic [7:0]  dvs;
        logic [15:0] q;
        logic [7:0]  r;
        logic        z;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain C-style integer division on the signed values.
    task automatic ref_div(input logic [15:0] a, input logic [7:0] b,
                           output logic [15:0] q, output logic [7:0] r, output logic z);
        int ai;
        int bi;
        ai = int'($signed(a));
        bi = int'($signed(b));
        if (bi == 0) begin
            z = 1'b1;
            q = (ai >= 0) ? 16'h7FFF : 16'h8000;
            r = a[7:0];
        end else begin
            int qi;
            int ri;
            z  = 1'b0;
            qi = ai / bi;
            ri = ai % bi;
            q  = qi[15:0];
            r  = ri[7:0];
        end
    endtask

    // One division from an idle/done DUT. Start is high in cycle 0; done is
    // expected in cycle 18 + stall_len. A stray start is pulsed mid-CALC.
    task automatic do_div(input logic [15:0] dvd, input logic [7:0] dvs,
                          input logic [15:0] eq, input logic [7:0] er, input logic ez,
                          input int stall_len, input string nm);
        int n;
        bit got;
        @(negedge clk);
        ce = 1'b1; start = 1'b1; dividend = dvd; divisor = dvs;
        n = 0; got = 0;
        while (!got && n < 60) begin
            @(negedge clk);
            n++;
            if (done) got = 1;
            if (n == 1) begin
                start = 1'b0;
                chk({nm, " ready_busy"}, {31'd0, ready}, 32'd0);
            end
            if (n == 5) begin start = 1'b1; dividend = 16'h1111; divisor = 8'h03; end
            if (n == 6) start = 1'b0;
            if (n == 17 && stall_len == 0) chk({nm, " ready_fix"}, {31'd0, ready}, 32'd0);
            if (stall_len > 0 && n == 9) ce = 1'b0;
            if (stall_len > 0 && n == 9 + stall_len) ce = 1'b1;
        end
        chk({nm, " latency"}, n, 18 + stall_len);
        chk({nm, " quotient"}, {16'd0, quotient}, {16'd0, eq});
        chk({nm, " remainder"}, {24'd0, remainder}, {24'd0, er});
        chk({nm, " dbz"}, {31'd0, div_by_zero}, {31'd0, ez});
        @(negedge clk);
        chk({nm, " done_clear"}, {30'd0, done, ready}, 32'd1);
    endtask

    vec_t vecs[$];

    initial begin
        logic [15:0] mq;
        logic [7:0]  mr;
        logic        mz;
        logic [15:0] rd;
        logic [7:0]  rv;
        int n;
        bit got;

        vecs.push_back('{16'd100,   8'd7,   16'd14,   8'd2,   1'b0});
        vecs.push_back('{16'hFF9C,  8'd7,   16'hFFF2, 8'hFE,  1'b0});
        vecs.push_back('{16'd100,   8'hF9,  16'hFFF2, 8'd2,   1'b0});
        vecs.push_back('{16'hFF9C,  8'hF9,  16'd14,   8'hFE,  1'b0});
        vecs.push_back('{16'h8000,  8'hFF,  16'h8000, 8'd0,   1'b0});
        vecs.push_back('{16'h7FFF,  8'h80,  16'hFF01, 8'h7F,  1'b0});
        vecs.push_back('{16'd1234,  8'd0,   16'h7FFF, 8'hD2,  1'b1});
        vecs.push_back('{16'hFFFB,  8'd0,   16'h8000, 8'hFB,  1'b1});
        vecs.push_back('{16'd9,     8'd3,   16'd3,    8'd0,   1'b0});
        vecs.push_back('{16'h8000,  8'h80,  16'd256,  8'd0,   1'b0});
        vecs.push_back('{16'd0,     8'd5,   16'd0,    8'd0,   1'b0});

        reset = 1'b1; ce = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        chk("reset outputs", {done, ready, div_by_zero, 5'd0, remainder, quotient}, 32'h4000_0000);
        reset = 1'b0;

        foreach (vecs[i])
            do_div(vecs[i].dvd, vecs[i].dvs, vecs[i].q, vecs[i].r, vecs[i].z, 0,
                   $sformatf("vec%0d", i));

        // ce stall of 5 cycles around CALC iteration 8.
        do_div(16'd100, 8'd7, 16'd14, 8'd2, 1'b0, 5, "stall");

        // Back-to-back: start held through CALC and DONE, operands swapped at DONE.
        @(negedge clk);
        ce = 1'b1; start = 1'b1; dividend = 16'd100; divisor = 8'd7;
        n = 0; got = 0;
        while (!got && n < 60) begin
            @(negedge clk); n++;
            if (done) got = 1;
        end
        chk("b2b first latency", n, 18);
        chk("b2b first q", {16'd0, quotient}, 32'd14);
        chk("b2b first r", {24'd0, remainder}, 32'd2);
        dividend = 16'd50; divisor = 8'd5;
        n = 0; got = 0;
        while (!got && n < 60) begin
            @(negedge clk); n++;
            if (n == 1) start = 1'b0;
            if (done) got = 1;
        end
        chk("b2b second latency", n, 18);
        chk("b2b second q", {16'd0, quotient}, 32'd10);
        chk("b2b second r", {24'd0, remainder}, 32'd0);

        // ce low during done: pulse stretches, clears after one enabled edge.
        ce = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("done stretched", {31'd0, done}, 32'd1);
        end
        ce = 1'b1;
        @(negedge clk);
        chk("done after ce", {30'd0, done, ready}, 32'd1);

        // Asynchronous reset mid-CALC.
        @(negedge clk);
        start = 1'b1; dividend = 16'd100; divisor = 8'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        #2 reset = 1'b1;
        #1 chk("async reset", {done, ready, div_by_zero, 5'd0, remainder, quotient}, 32'h4000_0000);
        @(negedge clk);
        reset = 1'b0;
        got = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) got = 1;
        end
        chk("no done after reset", {31'd0, got}, 32'd0);
        do_div(16'd100, 8'd7, 16'd14, 8'd2, 1'b0, 0, "post reset");

        // Randomized operands against the reference model.
        for (int k = 0; k < 40; k++) begin
            rd = 16'($urandom);
            rv = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            if (k == 3) rv = 8'h80;
            ref_div(rd, rv, mq, mr, mz);
            do_div(rd, rv, mq, mr, mz, (k % 8 == 5) ? 3 : 0, $sformatf("rand%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
